// File: rtl/alimentador_programa.sv
// Program sequencer for the multicycle processor: holds a loadable program
// memory and issues it word by word on DIN under the Run/Done handshake.
module alimentador_programa #(
  parameter int          DEPTH     = 32,
  parameter int          AW        = 5,
  parameter int          WAIT_MAX  = 16,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [7:0]    InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  // The internal PC is one bit wider so it can hold DEPTH (end of memory).
  localparam int PW = AW + 1;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [PW-1:0] DEPTH_A   = PW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [2:0]    OP_MVI    = 3'b001;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   din_q, din_d;
  logic          run_q, run_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic          error_q, error_d;
  logic [7:0]    count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [15:0]   mem [DEPTH];
  logic          idle_like;
  logic          wr_ok;
  logic [15:0]   word_at_pc;
  logic [15:0]   word_after_pc;
  logic          eval_en;
  logic [PW-1:0] eval_addr;
  logic [15:0]   eval_word;

  assign idle_like     = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);
  assign wr_ok         = WrEn && idle_like && (PW'(WrAddr) < DEPTH_A);
  assign word_at_pc    = mem[pc_q[AW-1:0]];
  assign word_after_pc = mem[pc_q[AW-1:0] + AW'(1)];

  // NOTE: the program memory has no reset; clearing it would force flops
  // instead of RAM, and the loaded program must survive a sequencer reset.
  always_ff @(posedge Clock) begin
    if (wr_ok) mem[WrAddr] <= WrData;
  end

  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    din_d     = '0;
    run_d     = 1'b0;
    halted_d  = halted_q;
    error_d   = error_q;
    count_d   = count_q;
    wait_d    = wait_q;
    eval_en   = 1'b0;
    eval_addr = pc_q;
    eval_word = word_at_pc;

    unique case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (Start) begin
          pc_d      = '0;
          count_d   = '0;
          halted_d  = 1'b0;
          error_d   = 1'b0;
          wait_d    = '0;
          eval_en   = 1'b1;
          eval_addr = '0;
          // A same-cycle write to address 0 must be seen by this evaluation.
          eval_word = (wr_ok && (WrAddr == '0)) ? WrData : mem[0];
        end
      end
      S_ISSUE: begin
        wait_d = '0;
        if (din_q[8:6] == OP_MVI) begin
          if ((pc_q + PW'(1)) >= DEPTH_A) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_IMM;
            pc_d    = pc_q + PW'(2);
            din_d   = word_after_pc;
          end
        end else begin
          state_d = S_WAIT;
          pc_d    = pc_q + PW'(1);
        end
      end
      S_IMM, S_WAIT: begin
        if (Done) begin
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          wait_d  = '0;
          eval_en = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          wait_d  = wait_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (eval_en) begin
      if ((eval_addr >= DEPTH_A) || (eval_word == HALT_WORD)) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else begin
        state_d = S_ISSUE;
        run_d   = 1'b1;
        din_d   = eval_word;
      end
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  assign DIN        = din_q;
  assign Run        = run_q;
  assign PC         = pc_q[AW-1:0];
  assign Busy       = busy_q;
  assign Halted     = halted_q;
  assign Error      = error_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_alimentador_programa.sv
// Directed bench for alimentador_programa: program load, handshake sequence,
// timeout, end-of-memory errors, async reset and busy-time write/start rules.
module tb_alimentador_programa;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [15:0] WrData;
  logic        Done;
  logic [15:0] DIN;
  logic        Run;
  logic [4:0]  PC;
  logic        Busy;
  logic        Halted;
  logic        Error;
  logic [7:0]  InstrCount;

  logic auto_en;
  logic done_man;
  logic done_r = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  alimentador_programa dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .Done      (Done),
    .DIN       (DIN),
    .Run       (Run),
    .PC        (PC),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  // Processor model: Done in the cycle right after each Run pulse.
  always @(posedge Clock) done_r <= Run;
  assign Done = auto_en ? done_r : done_man;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    WrEn   = 1'b1;
    WrAddr = a;
    WrData = d;
    tick();
    WrEn   = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    int  runs;
    logic prev_run;
    logic b2b;
    logic any_run;
    logic seen;

    Resetn   = 1'b0;
    Start    = 1'b0;
    WrEn     = 1'b0;
    WrAddr   = '0;
    WrData   = '0;
    auto_en  = 1'b1;
    done_man = 1'b0;
    #2;
    check("rst_din",    DIN, 16'h0000);
    check("rst_run",    Run, 1'b0);
    check("rst_pc",     PC, 5'd0);
    check("rst_busy",   Busy, 1'b0);
    check("rst_halted", Halted, 1'b0);
    check("rst_error",  Error, 1'b0);
    check("rst_count",  InstrCount, 8'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    tick();

    // mv, mvi + immediate, halt
    wr(5'd0, 16'h0008);
    wr(5'd1, 16'h0050);
    wr(5'd2, 16'h00AB);
    wr(5'd3, 16'hFFFF);
    pulse_start();
    check("seq_c1_run",  Run, 1'b1);
    check("seq_c1_din",  DIN, 16'h0008);
    check("seq_c1_pc",   PC, 5'd0);
    check("seq_c1_busy", Busy, 1'b1);
    tick();
    check("seq_c2_run", Run, 1'b0);
    check("seq_c2_din", DIN, 16'h0000);
    tick();
    check("seq_c3_run", Run, 1'b1);
    check("seq_c3_din", DIN, 16'h0050);
    check("seq_c3_pc",  PC, 5'd1);
    tick();
    check("seq_c4_run", Run, 1'b0);
    check("seq_c4_din", DIN, 16'h00AB);
    check("seq_c4_pc",  PC, 5'd3);
    tick();
    check("seq_halted", Halted, 1'b1);
    check("seq_busy",   Busy, 1'b0);
    check("seq_count",  InstrCount, 8'd2);
    check("seq_pc",     PC, 5'd3);
    check("seq_din",    DIN, 16'h0000);

    // Timeout: Done withheld after the first ISSUE
    auto_en = 1'b0;
    pulse_start();
    check("to_issue_run", Run, 1'b1);
    any_run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      any_run |= Run;
    end
    check("to_err_early", Error, 1'b0);
    check("to_busy_16",   Busy, 1'b1);
    tick();
    any_run |= Run;
    check("to_err_17",  Error, 1'b1);
    check("to_pc",      PC, 5'd1);
    check("to_busy",    Busy, 1'b0);
    check("to_no_run",  any_run, 1'b0);
    tick();
    check("to_err_hold", Error, 1'b1);
    check("to_run_hold", Run, 1'b0);

    // 32 adds filling the memory, then end-of-memory halt
    for (int i = 0; i < 32; i++) wr(5'(i), 16'h0081);
    auto_en = 1'b1;
    pulse_start();
    check("add_err_clr", Error, 1'b0);
    runs     = Run ? 1 : 0;
    prev_run = Run;
    b2b      = 1'b0;
    for (int i = 0; i < 200 && !Halted; i++) begin
      tick();
      if (Run) runs++;
      if (Run && prev_run) b2b = 1'b1;
      prev_run = Run;
    end
    check("add_halted", Halted, 1'b1);
    check("add_runs",   runs, 32);
    check("add_count",  InstrCount, 8'd32);
    check("add_b2b",    b2b, 1'b0);
    check("add_error",  Error, 1'b0);

    // mvi in the last word: no room for its immediate
    wr(5'd31, 16'h0050);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (Run && DIN == 16'h0050) seen = 1'b1;
      else tick();
    end
    check("mvi_end_seen", seen, 1'b1);
    check("mvi_end_pc_issue", PC, 5'd31);
    tick();
    check("mvi_end_err",    Error, 1'b1);
    check("mvi_end_pc",     PC, 5'd31);
    check("mvi_end_run",    Run, 1'b0);
    check("mvi_end_halted", Halted, 1'b0);
    check("mvi_end_count",  InstrCount, 8'd31);

    // Busy-time write and Start are ignored; async reset mid-WAIT
    auto_en = 1'b0;
    pulse_start();
    tick();
    check("busy_wait", Busy, 1'b1);
    wr(5'd0, 16'h1234);
    pulse_start();
    check("bs_busy", Busy, 1'b1);
    check("bs_run",  Run, 1'b0);
    check("bs_pc",   PC, 5'd1);
    check("bs_din",  DIN, 16'h0000);
    #3 Resetn = 1'b0;
    #1;
    check("ar_busy",  Busy, 1'b0);
    check("ar_pc",    PC, 5'd0);
    check("ar_count", InstrCount, 8'd0);
    check("ar_error", Error, 1'b0);
    check("ar_din",   DIN, 16'h0000);
    #1 Resetn = 1'b1;
    tick();
    check("ar_idle_run", Run, 1'b0);
    pulse_start();
    check("rr_run", Run, 1'b1);
    check("rr_pc",  PC, 5'd0);
    check("rr_din", DIN, 16'h0081);

    // Write and Start together: evaluation sees the new word at address 0
    #3 Resetn = 1'b0;
    #1 Resetn = 1'b1;
    tick();
    WrEn   = 1'b1;
    WrAddr = 5'd0;
    WrData = 16'hFFFF;
    Start  = 1'b1;
    tick();
    WrEn   = 1'b0;
    Start  = 1'b0;
    check("fw_halt",   Halted, 1'b1);
    check("fw_run",    Run, 1'b0);
    check("fw_busy",   Busy, 1'b0);
    WrEn   = 1'b1;
    WrData = 16'h0099;
    Start  = 1'b1;
    tick();
    WrEn   = 1'b0;
    Start  = 1'b0;
    check("fw2_run",    Run, 1'b1);
    check("fw2_din",    DIN, 16'h0099);
    check("fw2_halted", Halted, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
